// File: rtl/mandel_frame_scheduler_if.sv
// Solver and pixel-memory connections of the Mandelbrot frame scheduler.
// master = scheduler side, slave = solver + memory-writer side.
interface mandel_frame_scheduler_if #(
  parameter int CW = 27,
  parameter int IW = 13,
  parameter int AW = 19
);
  logic          solver_reset;
  logic [CW-1:0] solver_cr;
  logic [CW-1:0] solver_ci;
  logic [IW-1:0] solver_max;
  logic          solver_done;
  logic [IW-1:0] solver_iter;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_iter;

  modport master (
    output solver_reset, solver_cr, solver_ci, solver_max,
    input  solver_done, solver_iter,
    output wr_valid, wr_addr, wr_iter,
    input  wr_ready
  );

  modport slave (
    input  solver_reset, solver_cr, solver_ci, solver_max,
    output solver_done, solver_iter,
    input  wr_valid, wr_addr, wr_iter,
    output wr_ready
  );
endinterface

// File: rtl/mandel_frame_scheduler.sv
// Walks an H_RES x V_RES frame pixel by pixel: hands each c coordinate to one
// iteration solver, waits for its result and writes the count to pixel memory.
//
// state    | meaning
// S_IDLE   | solver held in reset, waiting for start
// S_LOAD   | coordinate on solver inputs, solver still in reset
// S_SETTLE | two cycles out of reset, stale solver_done ignored
// S_RUN    | waiting for solver_done
// S_WRITE  | pixel write offered until accepted
// S_DONE   | one-cycle frame_done pulse
module mandel_frame_scheduler #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int CW    = 27,
  parameter int IW    = 13,
  parameter int AW    = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [CW-1:0]            i_x_origin,
  input  logic [CW-1:0]            i_y_origin,
  input  logic [CW-1:0]            i_dx,
  input  logic [CW-1:0]            i_dy,
  input  logic [IW-1:0]            i_max_iter,
  mandel_frame_scheduler_if.master bus,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic [31:0]              o_frame_cycles
);
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_WRITE, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_settle_cnt;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [CW-1:0] r_x0;
  logic [CW-1:0] r_dx;
  logic [CW-1:0] r_dy;
  logic [CW-1:0] r_cr;
  logic [CW-1:0] r_ci;
  logic [IW-1:0] r_max;
  logic [IW-1:0] r_iter;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_cycles;
  logic          w_abort_ok;
  logic          w_start_ok;
  logic          w_accept;
  logic          w_last_pix;

  assign w_abort_ok = i_abort && (r_state != S_IDLE);
  assign w_start_ok = i_start && (r_state == S_IDLE);
  assign w_accept   = (r_state == S_WRITE) && bus.wr_ready && !i_abort;
  assign w_last_pix = (r_x == X_LAST) && (r_y == Y_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort_ok) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (i_start) w_state_nxt = S_LOAD;
        S_LOAD:   w_state_nxt = S_SETTLE;
        S_SETTLE: if (r_settle_cnt == 1'b0) w_state_nxt = S_RUN;
        S_RUN:    if (bus.solver_done) w_state_nxt = S_WRITE;
        S_WRITE:  if (w_accept) w_state_nxt = w_last_pix ? S_DONE : S_LOAD;
        S_DONE:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.solver_reset = (r_state == S_IDLE) || (r_state == S_LOAD);
    bus.wr_valid     = (r_state == S_WRITE);
    o_busy           = (r_state == S_LOAD) || (r_state == S_SETTLE) ||
                       (r_state == S_RUN)  || (r_state == S_WRITE);
    o_frame_done     = (r_state == S_DONE);
  end

  // The cycle counter also ticks in S_DONE, so the held value spans start accept
  // through the frame_done cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_settle_cnt <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_x0         <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_cr         <= '0;
      r_ci         <= '0;
      r_max        <= '0;
      r_iter       <= '0;
      r_addr       <= '0;
      r_cycles     <= '0;
    end else if (w_start_ok) begin
      r_x0     <= i_x_origin;
      r_dx     <= i_dx;
      r_dy     <= i_dy;
      r_cr     <= i_x_origin;
      r_ci     <= i_y_origin;
      r_max    <= i_max_iter;
      r_x      <= '0;
      r_y      <= '0;
      r_addr   <= '0;
      r_cycles <= '0;
    end else begin
      if (r_state != S_IDLE && r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'd1;
      if (r_state == S_LOAD)        r_settle_cnt <= 1'b1;
      else if (r_state == S_SETTLE) r_settle_cnt <= 1'b0;
      if (r_state == S_RUN && bus.solver_done && !i_abort) r_iter <= bus.solver_iter;
      if (w_accept) begin
        r_addr <= r_addr + 1'b1;
        if (r_x == X_LAST) begin
          r_x  <= '0;
          r_cr <= r_x0;
          r_y  <= r_y + 1'b1;
          r_ci <= r_ci - r_dy;
        end else begin
          r_x  <= r_x + 1'b1;
          r_cr <= r_cr + r_dx;
        end
      end
    end
  end

  assign bus.solver_cr  = r_cr;
  assign bus.solver_ci  = r_ci;
  assign bus.solver_max = r_max;
  assign bus.wr_addr    = r_addr;
  assign bus.wr_iter    = r_iter;
  assign o_frame_cycles = r_cycles;
endmodule

// File: tb/tb_mandel_frame_scheduler.sv
// Bench for mandel_frame_scheduler on a 4x3 frame with a behavioural solver and
// a pixel-memory model that stalls wr_ready per pixel.
module tb_mandel_frame_scheduler;
  localparam int H = 4;
  localparam int V = 3;
  localparam int NPIX = H * V;
  localparam int CW = 27;
  localparam int IW = 13;
  localparam int AW = 19;
  localparam int ONE = 1 << 23;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [CW-1:0] x_origin;
  logic [CW-1:0] y_origin;
  logic [CW-1:0] dx;
  logic [CW-1:0] dy;
  logic [IW-1:0] max_iter;
  logic          busy;
  logic          frame_done;
  logic [31:0]   frame_cycles;

  mandel_frame_scheduler_if #(.CW(CW), .IW(IW), .AW(AW)) ifc ();

  mandel_frame_scheduler #(.H_RES(H), .V_RES(V), .CW(CW), .IW(IW), .AW(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (start),
    .i_abort        (abort),
    .i_x_origin     (x_origin),
    .i_y_origin     (y_origin),
    .i_dx           (dx),
    .i_dy           (dy),
    .i_max_iter     (max_iter),
    .bus            (ifc),
    .o_busy         (busy),
    .o_frame_done   (frame_done),
    .o_frame_cycles (frame_cycles)
  );

  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int lat[NPIX];
  int stall[NPIX];
  int pix;
  int wcnt;
  int s_cnt;
  int done_cnt;
  logic [AW-1:0] q_addr[$];
  logic [IW-1:0] q_iter[$];
  logic [CW-1:0] q_cr[$];
  logic [CW-1:0] q_ci[$];
  logic [CW-1:0] v_x0, v_y0, v_dx, v_dy;
  logic [IW-1:0] v_max;

  function automatic logic [IW-1:0] f_iter(logic [CW-1:0] cr, logic [CW-1:0] ci, logic [IW-1:0] m);
    return cr[26:14] ^ ci[22:10] ^ m;
  endfunction

  function automatic logic [CW-1:0] exp_cr(int x);
    return v_x0 + CW'(x) * v_dx;
  endfunction

  function automatic logic [CW-1:0] exp_ci(int y);
    return v_y0 - CW'(y) * v_dy;
  endfunction

  // Solver model: done rises lat cycles after the two settle cycles.
  // Memory model: records every accepted write.
  initial begin
    pix = 0;
    s_cnt = 0;
    done_cnt = 0;
  end

  always @(posedge clk) begin
    if (start && !busy && !frame_done && !reset) pix = 0;
    else if (ifc.wr_valid && ifc.wr_ready && !abort && !reset) begin
      q_addr.push_back(ifc.wr_addr);
      q_iter.push_back(ifc.wr_iter);
      q_cr.push_back(ifc.solver_cr);
      q_ci.push_back(ifc.solver_ci);
      pix++;
    end
    if (frame_done) done_cnt++;
    if (ifc.solver_reset) begin
      s_cnt = 0;
      ifc.solver_done <= 1'b0;
    end else begin
      s_cnt++;
      ifc.solver_done <= (s_cnt >= ((pix < NPIX) ? lat[pix] : 1) + 1);
    end
    ifc.solver_iter <= f_iter(ifc.solver_cr, ifc.solver_ci, ifc.solver_max);
  end

  always @(negedge clk) begin
    int cs;
    cs = (pix < NPIX) ? stall[pix] : 0;
    if (!ifc.wr_valid) begin
      wcnt = 0;
      ifc.wr_ready = (cs == 0);
    end else if (wcnt < cs) begin
      wcnt++;
      ifc.wr_ready = 1'b0;
    end else begin
      ifc.wr_ready = 1'b1;
    end
  end

  task automatic launch(input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                        input logic [CW-1:0] ddx, input logic [CW-1:0] ddy,
                        input logic [IW-1:0] m);
    @(negedge clk);
    v_x0 = x0; v_y0 = y0; v_dx = ddx; v_dy = ddy; v_max = m;
    x_origin = x0; y_origin = y0; dx = ddx; dy = ddy; max_iter = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    bit found;
    for (int p = 0; p < NPIX; p++) begin lat[p] = 7; stall[p] = 0; end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL por_busy got=%0h exp=0", busy); end
    n_vec++; if (ifc.solver_reset !== 1'b1) begin n_err++; $display("FAIL por_solver_reset got=%0h exp=1", ifc.solver_reset); end
    n_vec++; if (frame_cycles !== 32'd0) begin n_err++; $display("FAIL por_frame_cycles got=%0d exp=0", frame_cycles); end
    launch(CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), IW'($urandom));
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!ifc.solver_reset) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rst_reach_settle got=timeout exp=solver_reset low"); end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done got=%0h exp=0", frame_done); end
    n_vec++; if (ifc.wr_valid !== 1'b0) begin n_err++; $display("FAIL rst_wr_valid got=%0h exp=0", ifc.wr_valid); end
    n_vec++; if (ifc.wr_addr !== '0) begin n_err++; $display("FAIL rst_wr_addr got=%0h exp=0", ifc.wr_addr); end
    n_vec++; if (ifc.wr_iter !== '0) begin n_err++; $display("FAIL rst_wr_iter got=%0h exp=0", ifc.wr_iter); end
    n_vec++; if (ifc.solver_reset !== 1'b1) begin n_err++; $display("FAIL rst_solver_reset got=%0h exp=1", ifc.solver_reset); end
    n_vec++; if (ifc.solver_cr !== '0) begin n_err++; $display("FAIL rst_solver_cr got=%0h exp=0", ifc.solver_cr); end
    n_vec++; if (ifc.solver_ci !== '0) begin n_err++; $display("FAIL rst_solver_ci got=%0h exp=0", ifc.solver_ci); end
    n_vec++; if (ifc.solver_max !== '0) begin n_err++; $display("FAIL rst_solver_max got=%0h exp=0", ifc.solver_max); end
    n_vec++; if (frame_cycles !== 32'd0) begin n_err++; $display("FAIL rst_frame_cycles got=%0d exp=0", frame_cycles); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_frame;
    bit ok;
    int qb, db, ec;
    for (int p = 0; p < NPIX; p++) begin lat[p] = $urandom_range(9, 1); stall[p] = 0; end
    qb = q_addr.size(); db = done_cnt;
    ec = 1;
    for (int p = 0; p < NPIX; p++) ec += 4 + lat[p] + stall[p];
    launch(CW'(-2 * ONE), CW'(ONE), CW'(ONE / 2), CW'(ONE / 2), IW'($urandom));
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL frame_done_seen got=timeout exp=pulse"); end
    n_vec++; if (q_addr.size() - qb !== NPIX) begin n_err++; $display("FAIL frame_writes got=%0d exp=%0d", q_addr.size() - qb, NPIX); end
    for (int i = 0; i < NPIX && qb + i < q_addr.size(); i++) begin
      n_vec++; if (q_addr[qb+i] !== AW'(i)) begin n_err++; $display("FAIL frame_addr[%0d] got=%0d exp=%0d", i, q_addr[qb+i], i); end
      n_vec++; if (q_iter[qb+i] !== f_iter(exp_cr(i % H), exp_ci(i / H), v_max)) begin
        n_err++; $display("FAIL frame_iter[%0d] got=%0h exp=%0h", i, q_iter[qb+i], f_iter(exp_cr(i % H), exp_ci(i / H), v_max)); end
    end
    if (q_cr.size() > qb + 5) begin
      n_vec++; if (q_cr[qb+5] !== CW'(-3 * ONE / 2)) begin n_err++; $display("FAIL pix5_cr got=%0h exp=%0h", q_cr[qb+5], CW'(-3 * ONE / 2)); end
      n_vec++; if (q_ci[qb+5] !== CW'(ONE / 2)) begin n_err++; $display("FAIL pix5_ci got=%0h exp=%0h", q_ci[qb+5], CW'(ONE / 2)); end
    end
    n_vec++; if (done_cnt - db !== 1) begin n_err++; $display("FAIL frame_done_count got=%0d exp=1", done_cnt - db); end
    n_vec++; if (frame_cycles !== 32'(ec)) begin n_err++; $display("FAIL frame_cycles_rand got=%0d exp=%0d", frame_cycles, ec); end
  endtask

  task automatic test_frame_cycles;
    bit ok;
    int qb;
    for (int p = 0; p < NPIX; p++) begin lat[p] = 7; stall[p] = 0; end
    qb = q_addr.size();
    launch(CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), IW'($urandom));
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL cyc_done_seen got=timeout exp=pulse"); end
    n_vec++; if (frame_cycles !== 32'(12 * (3 + 7 + 1) + 1)) begin n_err++; $display("FAIL cyc_frame_cycles got=%0d exp=%0d", frame_cycles, 12 * 11 + 1); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cyc_busy_after got=%0h exp=0", busy); end
    for (int i = 0; i < NPIX && qb + i < q_addr.size(); i++) begin
      n_vec++; if (q_iter[qb+i] !== f_iter(exp_cr(i % H), exp_ci(i / H), v_max)) begin
        n_err++; $display("FAIL cyc_iter[%0d] got=%0h exp=%0h", i, q_iter[qb+i], f_iter(exp_cr(i % H), exp_ci(i / H), v_max)); end
    end
  endtask

  task automatic test_stall;
    bit ok, found;
    int qb, ec;
    logic [IW-1:0] it;
    for (int p = 0; p < NPIX; p++) begin lat[p] = $urandom_range(9, 1); stall[p] = $urandom_range(2, 0); end
    stall[2] = 5;
    qb = q_addr.size();
    ec = 1;
    for (int p = 0; p < NPIX; p++) ec += 4 + lat[p] + stall[p];
    launch(CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), IW'($urandom));
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (ifc.wr_valid && ifc.wr_addr == AW'(2)) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL stall_reach_pix2 got=timeout exp=wr_valid addr 2"); end
    it = f_iter(exp_cr(2), exp_ci(0), v_max);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      n_vec++; if (ifc.wr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got=%0h exp=1", k, ifc.wr_valid); end
      n_vec++; if (ifc.wr_addr !== AW'(2)) begin n_err++; $display("FAIL stall_addr[%0d] got=%0d exp=2", k, ifc.wr_addr); end
      n_vec++; if (ifc.wr_iter !== it) begin n_err++; $display("FAIL stall_iter[%0d] got=%0h exp=%0h", k, ifc.wr_iter, it); end
    end
    n_vec++; if (q_addr.size() - qb !== 2) begin n_err++; $display("FAIL stall_no_advance got=%0d exp=2", q_addr.size() - qb); end
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stall_done_seen got=timeout exp=pulse"); end
    n_vec++; if (frame_cycles !== 32'(ec)) begin n_err++; $display("FAIL stall_frame_cycles got=%0d exp=%0d", frame_cycles, ec); end
    for (int i = 0; i < NPIX && qb + i < q_addr.size(); i++) begin
      n_vec++; if (q_addr[qb+i] !== AW'(i)) begin n_err++; $display("FAIL stall_frame_addr[%0d] got=%0d exp=%0d", i, q_addr[qb+i], i); end
    end
  endtask

  task automatic test_abort;
    bit found;
    int qb, db, ec;
    for (int p = 0; p < NPIX; p++) begin lat[p] = $urandom_range(9, 1); stall[p] = $urandom_range(2, 0); end
    stall[6] = 3;
    qb = q_addr.size(); db = done_cnt;
    ec = 3 + lat[6] + 1;
    for (int p = 0; p < 6; p++) ec += 4 + lat[p] + stall[p];
    launch(CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), IW'($urandom));
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (ifc.wr_valid && ifc.wr_addr == AW'(6)) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL abort_reach_pix6 got=timeout exp=wr_valid addr 6"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_vec++; if (ifc.wr_valid !== 1'b0) begin n_err++; $display("FAIL abort_wr_valid got=%0h exp=0", ifc.wr_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%0h exp=0", busy); end
    n_vec++; if (ifc.solver_reset !== 1'b1) begin n_err++; $display("FAIL abort_solver_reset got=%0h exp=1", ifc.solver_reset); end
    n_vec++; if (frame_cycles !== 32'(ec)) begin n_err++; $display("FAIL abort_frame_cycles got=%0d exp=%0d", frame_cycles, ec); end
    repeat (5) @(negedge clk);
    n_vec++; if (done_cnt - db !== 0) begin n_err++; $display("FAIL abort_no_frame_done got=%0d exp=0", done_cnt - db); end
    n_vec++; if (frame_cycles !== 32'(ec)) begin n_err++; $display("FAIL abort_cycles_hold got=%0d exp=%0d", frame_cycles, ec); end
    n_vec++; if (q_addr.size() - qb !== 6) begin n_err++; $display("FAIL abort_write_count got=%0d exp=6", q_addr.size() - qb); end
  endtask

  task automatic test_start_busy;
    bit ok, found;
    int qb, db, ec;
    for (int p = 0; p < NPIX; p++) begin lat[p] = $urandom_range(9, 1); stall[p] = $urandom_range(2, 0); end
    qb = q_addr.size(); db = done_cnt;
    ec = 1;
    for (int p = 0; p < NPIX; p++) ec += 4 + lat[p] + stall[p];
    launch(CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), IW'($urandom));
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (q_addr.size() - qb >= 5) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL busy_reach_pix5 got=timeout exp=5 writes"); end
    x_origin = ~v_x0; y_origin = ~v_y0; dx = ~v_dx; dy = ~v_dy; max_iter = ~v_max;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_still_busy got=%0h exp=1", busy); end
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL busy_done_seen got=timeout exp=pulse"); end
    n_vec++; if (q_addr.size() - qb !== NPIX) begin n_err++; $display("FAIL busy_writes got=%0d exp=%0d", q_addr.size() - qb, NPIX); end
    for (int i = 0; i < NPIX && qb + i < q_addr.size(); i++) begin
      n_vec++; if (q_iter[qb+i] !== f_iter(exp_cr(i % H), exp_ci(i / H), v_max)) begin
        n_err++; $display("FAIL busy_iter[%0d] got=%0h exp=%0h", i, q_iter[qb+i], f_iter(exp_cr(i % H), exp_ci(i / H), v_max)); end
    end
    n_vec++; if (done_cnt - db !== 1) begin n_err++; $display("FAIL busy_done_count got=%0d exp=1", done_cnt - db); end
    n_vec++; if (frame_cycles !== 32'(ec)) begin n_err++; $display("FAIL busy_frame_cycles got=%0d exp=%0d", frame_cycles, ec); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=bench finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    x_origin = '0; y_origin = '0; dx = '0; dy = '0; max_iter = '0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_frame;
    test_frame_cycles;
    test_stall;
    test_abort;
    test_start_busy;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
